// File: rtl/stream_pattern_tester.sv
// Valid/ready traffic generator and checker for the FTDI FIFO bridge.
// The TX side emits a pattern stream; the RX side locks onto a seed word and counts mismatches.
module stream_pattern_tester #(
    parameter int TX_W = 64,
    parameter int RX_W = 8,
    parameter int HOLD = 50000000
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            en,
    input  logic [1:0]      mode,
    output logic            tx_valid,
    input  logic            tx_ready,
    output logic [TX_W-1:0] tx_data,
    input  logic            rx_valid,
    output logic            rx_ready,
    input  logic [RX_W-1:0] rx_data,
    output logic            locked,
    output logic            err_led,
    output logic [15:0]     err_cnt,
    output logic [31:0]     tx_cnt,
    output logic [31:0]     rx_cnt
);
    localparam int TMR_W = $clog2(HOLD + 1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SEED = 2'd1, ST_CHECK = 2'd2} chk_state_t;

    // Byte mode adds the lane count to every lane so the wire sees a continuous byte ramp.
    function automatic logic [TX_W-1:0] tx_next(input logic [TX_W-1:0] x, input logic byte_mode);
        logic [TX_W-1:0] r;
        r = x;
        if (byte_mode) begin
            for (int i = 0; i < TX_W / 8; i++) r[8*i +: 8] = x[8*i +: 8] + 8'(TX_W / 8);
        end else begin
            r = x + {{(TX_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    function automatic logic [RX_W-1:0] rx_next(input logic [RX_W-1:0] x, input logic byte_mode);
        logic [RX_W-1:0] r;
        r = x;
        if (byte_mode) begin
            for (int i = 0; i < RX_W / 8; i++) r[8*i +: 8] = x[8*i +: 8] + 8'(RX_W / 8);
        end else begin
            r = x + {{(RX_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    function automatic logic [TX_W-1:0] tx_seed(input logic byte_mode);
        logic [TX_W-1:0] r;
        r = '0;
        if (byte_mode) begin
            for (int i = 0; i < TX_W / 8; i++) r[8*i +: 8] = 8'(i);
        end else begin
            r = '0;
        end
        return r;
    endfunction

    logic             en_q;
    logic [1:0]       mode_q, mode_d;
    logic             tx_valid_q, tx_valid_d;
    logic [TX_W-1:0]  tx_data_q, tx_data_d;
    logic [31:0]      tx_cnt_q, tx_cnt_d;
    logic             rx_ready_q;
    chk_state_t       st_q, st_d;
    logic [RX_W-1:0]  expect_q, expect_d;
    logic             locked_q, locked_d;
    logic [15:0]      err_cnt_q, err_cnt_d;
    logic [31:0]      rx_cnt_q, rx_cnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             err_led_q;
    logic             en_rise_s, tx_hs_s, rx_hs_s, mismatch_s;

    // Next-state logic for generator, checker and LED timer.
    always_comb begin
        en_rise_s  = en & ~en_q;
        tx_hs_s    = tx_valid_q & tx_ready;
        rx_hs_s    = rx_valid & rx_ready_q;
        mismatch_s = 1'b0;
        mode_d     = mode_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        tx_cnt_d   = tx_cnt_q;
        st_d       = st_q;
        expect_d   = expect_q;
        locked_d   = locked_q;
        err_cnt_d  = err_cnt_q;
        rx_cnt_d   = rx_cnt_q;

        // A pending word is held after en falls; valid only drops on a handshake.
        if (en_rise_s) begin
            mode_d     = mode;
            tx_valid_d = ~mode[1];
            tx_data_d  = tx_seed(mode == 2'd1);
            tx_cnt_d   = 32'd0;
        end else if (tx_hs_s) begin
            tx_data_d  = tx_next(tx_data_q, mode_q == 2'd1);
            tx_cnt_d   = tx_cnt_q + 32'd1;
            tx_valid_d = en & ~mode_q[1];
        end else begin
            tx_valid_d = tx_valid_q;
        end

        if (en_rise_s) begin
            st_d      = ST_SEED;
            rx_cnt_d  = 32'd0;
            err_cnt_d = 16'd0;
            locked_d  = 1'b0;
        end else if (!en) begin
            st_d = ST_IDLE;
        end else begin
            case (st_q)
                ST_SEED: begin
                    if (rx_hs_s) begin
                        expect_d = rx_next(rx_data, mode_q == 2'd1);
                        locked_d = 1'b1;
                        rx_cnt_d = rx_cnt_q + 32'd1;
                        st_d     = ST_CHECK;
                    end else begin
                        st_d = ST_SEED;
                    end
                end
                ST_CHECK: begin
                    if (rx_hs_s) begin
                        rx_cnt_d   = rx_cnt_q + 32'd1;
                        mismatch_s = (rx_data != expect_q);
                        expect_d   = rx_next(rx_data, mode_q == 2'd1);
                        if (mismatch_s) begin
                            err_cnt_d = (err_cnt_q == 16'hFFFF) ? err_cnt_q : err_cnt_q + 16'd1;
                        end else begin
                            err_cnt_d = err_cnt_q;
                        end
                    end else begin
                        st_d = ST_CHECK;
                    end
                end
                default: st_d = ST_IDLE;
            endcase
        end

        if (mismatch_s) begin
            tmr_d = TMR_W'(HOLD);
        end else if (tmr_q != '0) begin
            tmr_d = tmr_q - {{(TMR_W-1){1'b0}}, 1'b1};
        end else begin
            tmr_d = tmr_q;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            en_q       <= 1'b0;
            mode_q     <= 2'd0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            tx_cnt_q   <= 32'd0;
            rx_ready_q <= 1'b0;
            st_q       <= ST_IDLE;
            expect_q   <= '0;
            locked_q   <= 1'b0;
            err_cnt_q  <= 16'd0;
            rx_cnt_q   <= 32'd0;
            tmr_q      <= '0;
            err_led_q  <= 1'b0;
        end else begin
            en_q       <= en;
            mode_q     <= mode_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_ready_q <= 1'b1;
            st_q       <= st_d;
            expect_q   <= expect_d;
            locked_q   <= locked_d;
            err_cnt_q  <= err_cnt_d;
            rx_cnt_q   <= rx_cnt_d;
            tmr_q      <= tmr_d;
            err_led_q  <= (tmr_d != '0);
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign tx_cnt   = tx_cnt_q;
    assign rx_ready = rx_ready_q;
    assign locked   = locked_q;
    assign err_cnt  = err_cnt_q;
    assign rx_cnt   = rx_cnt_q;
    assign err_led  = err_led_q;
endmodule

// File: tb/tb_stream_pattern_tester.sv
// Scoreboard bench for stream_pattern_tester: expected TX words are queued by the stimulus
// and popped by a monitor on every TX handshake; counters and flags are compared directly.
module tb_stream_pattern_tester;
    logic        clk;
    logic        rstn;
    logic        en;
    logic [1:0]  mode;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] tx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        locked;
    logic        err_led;
    logic [15:0] err_cnt;
    logic [31:0] tx_cnt;
    logic [31:0] rx_cnt;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mon_e;

    stream_pattern_tester #(.TX_W(32), .RX_W(8), .HOLD(4)) dut (
        .clk(clk), .rstn(rstn), .en(en), .mode(mode),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .locked(locked), .err_led(err_led), .err_cnt(err_cnt),
        .tx_cnt(tx_cnt), .rx_cnt(rx_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every TX handshake consumes the oldest expected word.
    always @(negedge clk) begin
        if (rstn && tx_valid && tx_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL tx_unexpected actual=%h required=none", tx_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (tx_data !== mon_e) begin
                    failures++;
                    $display("FAIL tx_word actual=%h required=%h", tx_data, mon_e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [31:0] expw;
    int          hs;
    logic [7:0]  rxb [5];
    logic [7:0]  bb;

    initial begin
        rstn = 1'b0; en = 1'b0; mode = 2'd0; tx_ready = 1'b0;
        rx_valid = 1'b0; rx_data = 8'd0;
        rxb[0] = 8'd5; rxb[1] = 8'd6; rxb[2] = 8'd7; rxb[3] = 8'd9; rxb[4] = 8'd10;

        // Reset values.
        #12;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err_led", err_led, 0);
        chk("rst_counts", {err_cnt, tx_cnt, rx_cnt[15:0]}, 0);
        #10 rstn = 1'b1;
        step(1);
        chk("rx_ready_after_rst", rx_ready, 1);

        // Mode 0 word increment, five back-to-back transfers.
        for (int i = 0; i < 5; i++) exp_q.push_back(32'(i));
        mode = 2'd0; en = 1'b1; tx_ready = 1'b1;
        step(1);
        chk("m0_valid_after_rise", tx_valid, 1);
        chk("m0_seed", tx_data, 32'd0);
        step(5);
        tx_ready = 1'b0;
        chk("m0_tx_cnt5", tx_cnt, 32'd5);
        chk("m0_tx_data5", tx_data, 32'd5);

        // Random backpressure.
        expw = 32'd5; hs = 0;
        for (int i = 0; i < 20; i++) begin
            tx_ready = 1'($urandom_range(0, 1));
            if (tx_ready) begin
                exp_q.push_back(expw);
                expw = expw + 32'd1;
                hs++;
            end
            step(1);
        end
        tx_ready = 1'b0;
        chk("m0_tx_cnt_rand", tx_cnt, 32'(5 + hs));
        step(1);
        chk("m0_hold_when_stalled", tx_data, expw);

        // Checker resync on 5,6,7,9,10.
        for (int i = 0; i < 5; i++) begin
            rx_valid = 1'b1; rx_data = rxb[i];
            step(1);
            if (i == 0) chk("rx_locked_after_seed", locked, 1);
            if (i == 2) chk("rx_no_err_yet", err_cnt, 0);
            if (i == 3) begin
                chk("rx_err_at_9", err_cnt, 1);
                chk("rx_led_at_9", err_led, 1);
            end
            if (i == 4) chk("rx_no_err_at_10", err_cnt, 1);
        end
        rx_valid = 1'b0;
        chk("rx_cnt5", rx_cnt, 32'd5);

        // en drop with stalled TX; RX while disabled is discarded.
        en = 1'b0; rx_valid = 1'b1; rx_data = 8'h33;
        step(3);
        rx_valid = 1'b0;
        chk("drop_valid_held", tx_valid, 1);
        chk("drop_data_held", tx_data, expw);
        chk("drop_rx_cnt", rx_cnt, 32'd5);
        exp_q.push_back(expw);
        tx_ready = 1'b1;
        step(1);
        tx_ready = 1'b0;
        chk("drop_valid_low", tx_valid, 0);
        chk("drop_tx_cnt", tx_cnt, 32'(6 + hs));
        step(1);
        chk("drop_valid_stays_low", tx_valid, 0);

        // Mode 2: TX idle, checker in mode 0 with byte wrap.
        mode = 2'd2; en = 1'b1; tx_ready = 1'b1;
        step(2);
        chk("m2_tx_idle", tx_valid, 0);
        tx_ready = 1'b0;
        rx_valid = 1'b1; rx_data = 8'hFF; step(1);
        rx_data = 8'h00; step(1);
        rx_valid = 1'b0;
        chk("m2_wrap_no_err", err_cnt, 0);
        chk("m2_rx_cnt", rx_cnt, 32'd2);
        en = 1'b0;
        step(1);

        // Mode 1 byte sequence including lane wrap; RX in the en-rise cycle is ignored.
        for (int i = 0; i < 66; i++) begin
            bb = 8'(4 * i);
            exp_q.push_back({bb + 8'd3, bb + 8'd2, bb + 8'd1, bb});
        end
        mode = 2'd1; en = 1'b1; tx_ready = 1'b1;
        rx_valid = 1'b1; rx_data = 8'h20;
        step(1);
        chk("m1_seed", tx_data, 32'h03020100);
        chk("m1_counts_cleared", rx_cnt, 32'd0);
        rx_data = 8'h50; step(1);
        rx_data = 8'h51; step(1);
        rx_valid = 1'b0;
        step(64);
        tx_ready = 1'b0;
        chk("m1_tx_cnt", tx_cnt, 32'd66);
        chk("m1_after_wrap", tx_data, 32'h0B0A0908);
        chk("m1_rx_cnt", rx_cnt, 32'd2);
        chk("m1_err_cnt", err_cnt, 0);

        // LED stretch: mismatches two cycles apart, HOLD=4.
        for (int j = 0; j < 7; j++) begin
            rx_valid = (j < 3);
            rx_data  = (j == 0) ? 8'h99 : (j == 1) ? 8'h9A : 8'h00;
            step(1);
            chk($sformatf("led_cycle%0d", j), err_led, (j < 6) ? 1 : 0);
        end
        chk("led_err_cnt", err_cnt, 16'd2);

        // Saturate err_cnt.
        rx_valid = 1'b1; rx_data = 8'h00;
        step(70000);
        rx_valid = 1'b0;
        chk("err_cnt_sat", err_cnt, 16'hFFFF);
        chk("rx_cnt_after_sat", rx_cnt, 32'd70005);

        // Asynchronous reset between edges, then re-enable in mode 1.
        #3 rstn = 1'b0;
        #1;
        chk("arst_tx_valid", tx_valid, 0);
        chk("arst_tx_data", tx_data, 0);
        chk("arst_rx_ready", rx_ready, 0);
        chk("arst_flags", {locked, err_led}, 0);
        chk("arst_counts", {err_cnt, tx_cnt, rx_cnt[15:0]}, 0);
        en = 1'b0;
        #2 rstn = 1'b1;
        step(1);
        exp_q.push_back(32'h03020100);
        exp_q.push_back(32'h07060504);
        mode = 2'd1; en = 1'b1; tx_ready = 1'b1;
        step(1);
        step(2);
        tx_ready = 1'b0;
        step(1);
        chk("rearm_tx_cnt", tx_cnt, 32'd2);
        chk("rearm_tx_data", tx_data, 32'h0B0A0908);
        chk("tx_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
